regfile_wb_arbiter: RTL

Shares the register file's single write port between two writeback sources: the main pipeline (requester A) and the multi-cycle multiply/divide unit (requester B). Arbitration is round-robin with valid/ready handshakes. The write to the register file is registered. The block also keeps a pending-write scoreboard for long-latency destinations, which decode queries to stall on RAW/WAW hazards. It sits between the writeback stage and the register file's write port (REG_write_1 / REG_address_wr / REG_data_wb_in1).

---
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// It also keeps a pending-write scoreboard for long-latency destinations.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_valid,
    input  logic [ADDR_W-1:0] A_addr,
    input  logic [DATA_W-1:0] A_data,
    output logic              A_ready,
    input  logic              B_valid,
    input  logic [ADDR_W-1:0] B_addr,
    input  logic [DATA_W-1:0] B_data,
    output logic              B_ready,
    input  logic              ISSUE_valid,
    input  logic [ADDR_W-1:0] ISSUE_addr,
    output logic              ISSUE_ready,
    input  logic [ADDR_W-1:0] Q_addr1,
    input  logic [ADDR_W-1:0] Q_addr2,
    output logic              Q_busy1,
    output logic              Q_busy2,
    output logic              REG_write_1,
    output logic [ADDR_W-1:0] REG_address_wr,
    output logic [DATA_W-1:0] REG_data_wb_in1
);

    // pref_q: 0 = A has priority on contention, 1 = B has priority
    logic              pref_q, pref_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_data_q, reg_data_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              grant_a, grant_b;
    logic              a_xfer, b_xfer;
    logic              issue_set;

    always_comb begin
        grant_a     = A_valid & (~B_valid | ~pref_q);
        grant_b     = B_valid & (~A_valid | pref_q);
        a_xfer      = grant_a & ~RESET;
        b_xfer      = grant_b & ~RESET;
        ISSUE_ready = ~pending_q[ISSUE_addr] | (ISSUE_addr == '0);
        issue_set   = ISSUE_valid & ISSUE_ready & (ISSUE_addr != '0) & ~RESET;

        pref_d     = pref_q;
        reg_we_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        if (a_xfer) begin
            pref_d     = 1'b1;
            reg_we_d   = (A_addr != '0);
            reg_addr_d = A_addr;
            reg_data_d = A_data;
        end else if (b_xfer) begin
            pref_d     = 1'b0;
            reg_we_d   = (B_addr != '0);
            reg_addr_d = B_addr;
            reg_data_d = B_data;
        end
    end

    // Per-register scoreboard update; a set in the same cycle as a clear wins.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
            always_comb begin
                pending_d[gi] = pending_q[gi];
                if (b_xfer && (B_addr == ADDR_W'(gi)))
                    pending_d[gi] = 1'b0;
                if (issue_set && (ISSUE_addr == ADDR_W'(gi)))
                    pending_d[gi] = 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pref_q     <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            pending_q  <= '0;
        end else begin
            pref_q     <= pref_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            pending_q  <= pending_d;
        end
    end

    assign A_ready         = a_xfer;
    assign B_ready         = b_xfer;
    assign REG_write_1     = reg_we_q;
    assign REG_address_wr  = reg_addr_q;
    assign REG_data_wb_in1 = reg_data_q;

    // The in-flight term keeps a register busy until its write lands in the file.
    assign Q_busy1 = (Q_addr1 != '0) &
                     (pending_q[Q_addr1] | (reg_we_q & (reg_addr_q == Q_addr1)));
    assign Q_busy2 = (Q_addr2 != '0) &
                     (pending_q[Q_addr2] | (reg_we_q & (reg_addr_q == Q_addr2)));

endmodule
